ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 110 +++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - credit-based instruction fetch queue with flush/discard handling
// Optional define IFETCH_QUEUE_PERF_CNT_EN adds push and flush performance counters.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef IFETCH_QUEUE_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [CW-1:0] count, outstanding, discard, outstanding_next;
  logic [AW-1:0] wptr, rptr;
  logic [31:0]   fetch_pc, resp_pc;
  logic          started;
  logic [CW:0]   credit_used;
  logic          accept, rsp, push, pop;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  // started keeps imem_req low until the first edge after reset release
  assign imem_req    = started && !flush && (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_gnt;
  assign rsp         = imem_rvalid && (outstanding != '0);
  assign push        = rsp && (discard == '0) && !flush;
  assign pop         = inst_valid && inst_ready && !flush;

  assign inst_valid  = (count != '0);
  assign inst        = inst_valid ? mem_data[rptr] : 32'h0;
  assign inst_pc     = inst_valid ? mem_pc[rptr]   : 32'h0;

  always_comb begin
    outstanding_next = outstanding + CW'(accept) - CW'(rsp);
  end

  // resp_pc tracks the address of the oldest non-discarded outstanding request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_next;
      if (flush) begin
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
        fetch_pc <= {flush_pc[31:2], 2'b00};
        resp_pc  <= {flush_pc[31:2], 2'b00};
        discard  <= outstanding_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (rsp) begin
          if (discard != '0) discard <= discard - 1'b1;
          else               resp_pc <= resp_pc + 32'd4;
        end
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= imem_rdata;
      mem_pc[wptr]   <= resp_pc;
    end
  end

`ifdef IFETCH_QUEUE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (push)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
